// File: rtl/alarm_controller.sv
// Anti-theft sequencing controller: arming/entry-delay FSM, internal 1 s tick
// prescaler with a seconds countdown, and registered siren / fuel-pump / LED drives.
module alarm_controller #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int T_ARM_DELAY = 6,
    parameter int T_DRIVER    = 8,
    parameter int T_PASSENGER = 15,
    parameter int T_ALARM_ON  = 10
) (
    input  logic       clock_in,
    input  logic       reset_n_in,
    input  logic       ignition_in,
    input  logic       driver_door_in,
    input  logic       passenger_door_in,
    input  logic       hidden_sw_in,
    input  logic       brake_in,
    output logic       siren_out,
    output logic       fuel_pump_out,
    output logic       status_led_out,
    output logic [2:0] state_out
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [2:0] {
        S_ARMED      = 3'd0,
        S_TRIGGERED  = 3'd1,
        S_SOUNDING   = 3'd2,
        S_SIREN_HOLD = 3'd3,
        S_DISARMED   = 3'd4,
        S_WAIT_OPEN  = 3'd5,
        S_WAIT_CLOSE = 3'd6,
        S_ARM_DELAY  = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          siren_q, siren_d;
    logic          led_q, led_d;
    logic          fuel_q, fuel_d;

    logic          tick;
    logic          expire;
    logic          load;
    logic [7:0]    load_val;
    logic          any_door;

    assign tick     = (presc_q == PW'(CLK_HZ - 1));
    // count reads zero only after the final tick, which yields T*CLK_HZ+1 cycles per timed state
    assign expire   = (cnt_q == 8'd0);
    assign any_door = driver_door_in | passenger_door_in;

    // Next-state logic; ignition always forces DISARMED, timed entries request a load
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = 8'd0;
        if (ignition_in) begin
            state_d = S_DISARMED;
        end else begin
            case (state_q)
                S_DISARMED: state_d = S_WAIT_OPEN;
                S_WAIT_OPEN: begin
                    if (driver_door_in) state_d = S_WAIT_CLOSE;
                end
                S_WAIT_CLOSE: begin
                    if (!driver_door_in) begin
                        state_d  = S_ARM_DELAY;
                        load     = 1'b1;
                        load_val = 8'(T_ARM_DELAY);
                    end
                end
                S_ARM_DELAY: begin
                    if (any_door)    state_d = S_WAIT_CLOSE;
                    else if (expire) state_d = S_ARMED;
                end
                S_ARMED: begin
                    // driver door takes precedence when both open together
                    if (driver_door_in) begin
                        state_d  = S_TRIGGERED;
                        load     = 1'b1;
                        load_val = 8'(T_DRIVER);
                    end else if (passenger_door_in) begin
                        state_d  = S_TRIGGERED;
                        load     = 1'b1;
                        load_val = 8'(T_PASSENGER);
                    end
                end
                S_TRIGGERED: begin
                    if (expire) state_d = S_SOUNDING;
                end
                S_SOUNDING: begin
                    if (!any_door) begin
                        state_d  = S_SIREN_HOLD;
                        load     = 1'b1;
                        load_val = 8'(T_ALARM_ON);
                    end
                end
                S_SIREN_HOLD: begin
                    if (any_door)    state_d = S_SOUNDING;
                    else if (expire) state_d = S_ARMED;
                end
                default: state_d = S_ARMED;
            endcase
        end
    end

    // Prescaler and seconds counter: a load restarts both, otherwise free-run / saturating count
    always_comb begin
        presc_d = presc_q + 1'b1;
        cnt_d   = cnt_q;
        if (load) begin
            presc_d = '0;
            cnt_d   = load_val;
        end else begin
            if (tick) presc_d = '0;
            if (tick && (cnt_q != 8'd0)) cnt_d = cnt_q - 8'd1;
        end
    end

    // Output next values, decoded from the upcoming state so they change with it
    always_comb begin
        siren_d = (state_d == S_SOUNDING) || (state_d == S_SIREN_HOLD);
        led_d   = 1'b0;
        case (state_d)
            S_ARMED: begin
                if (state_q != S_ARMED) led_d = 1'b1;
                else if (tick)          led_d = ~led_q;
                else                    led_d = led_q;
            end
            S_TRIGGERED, S_SOUNDING, S_SIREN_HOLD: led_d = 1'b1;
            default: led_d = 1'b0;
        endcase
        fuel_d = fuel_q;
        if (ignition_in && hidden_sw_in && brake_in) fuel_d = 1'b1;
        else if (!ignition_in)                       fuel_d = 1'b0;
    end

    // All state and output registers, asynchronously reset into ARMED
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= S_ARMED;
            presc_q <= '0;
            cnt_q   <= 8'd0;
            siren_q <= 1'b0;
            led_q   <= 1'b1;
            fuel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            siren_q <= siren_d;
            led_q   <= led_d;
            fuel_q  <= fuel_d;
        end
    end

    assign siren_out      = siren_q;
    assign fuel_pump_out  = fuel_q;
    assign status_led_out = led_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with a 10-cycle tick.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ign, drv, pas, hid, brk;
    logic       siren, fuel, led;
    logic [2:0] st;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ign, drv, pas, hid, brk;
        logic [2:0] st;
        logic       siren, led, fuel;
    } vec_t;

    vec_t vecs[9];

    alarm_controller #(
        .CLK_HZ(10), .T_ARM_DELAY(6), .T_DRIVER(8), .T_PASSENGER(15), .T_ALARM_ON(10)
    ) dut (
        .clock_in(clk), .reset_n_in(rst_n), .ignition_in(ign),
        .driver_door_in(drv), .passenger_door_in(pas), .hidden_sw_in(hid),
        .brake_in(brk), .siren_out(siren), .fuel_pump_out(fuel),
        .status_led_out(led), .state_out(st)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int e_st, input int e_siren, input int e_led);
        chk({tag, "_state"}, int'(st), e_st);
        chk({tag, "_siren"}, int'(siren), e_siren);
        chk({tag, "_led"}, int'(led), e_led);
    endtask

    // cycles spent in state s, counting the entry cycle; bounded by max
    task automatic measure(input logic [2:0] s, input int max, output int n);
        n = 1;
        for (int i = 0; i < max; i++) begin
            step();
            if (st != s) break;
            n++;
        end
    endtask

    // steps until the LED changes from its current value; bounded by max
    task automatic led_interval(input int max, output int n);
        logic start;
        start = led;
        n = 0;
        for (int i = 0; i < max; i++) begin
            step();
            n++;
            if (led != start) break;
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        ign = 0; drv = 0; pas = 0; hid = 0; brk = 0;
        repeat (3) @(posedge clk);
        #1;
        outs("reset", 0, 0, 1);
        chk("reset_fuel", int'(fuel), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fuel-pump gating, disarm and door sequence into ARM_DELAY
        for (int i = 0; i < 9; i++) begin
            ign = vecs[i].ign; drv = vecs[i].drv; pas = vecs[i].pas;
            hid = vecs[i].hid; brk = vecs[i].brk;
            step();
            outs($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].siren), int'(vecs[i].led));
            chk($sformatf("vec%0d_fuel", i), int'(fuel), int'(vecs[i].fuel));
        end

        // door reopened partway through ARM_DELAY returns to WAIT_CLOSE
        repeat (29) step();
        chk("arm_delay_mid_state", int'(st), 7);
        pas = 1; step();
        chk("arm_delay_reopen_state", int'(st), 6);
        pas = 0; step();
        chk("arm_delay_reentry_state", int'(st), 7);
        measure(3'd7, 300, n);
        chk("arm_delay_len", n, 61);
        outs("armed_entry", 0, 0, 1);

        // blinking LED in ARMED: first edge 9 cycles after entry, then every 10
        led_interval(30, n);
        chk("led_first_toggle", n, 9);
        led_interval(30, n);
        chk("led_period_a", n, 10);
        led_interval(30, n);
        chk("led_period_b", n, 10);
        chk("armed_still_state", int'(st), 0);

        // passenger entry delay, siren, hold with a mid-hold reopen
        pas = 1; step();
        outs("pas_trig", 1, 0, 1);
        measure(3'd1, 400, n);
        chk("pas_trig_len", n, 151);
        outs("sounding", 2, 1, 1);
        repeat (3) step();
        chk("sounding_door_open_state", int'(st), 2);
        pas = 0; step();
        outs("hold_entry", 3, 1, 1);
        repeat (49) step();
        chk("hold_mid_state", int'(st), 3);
        pas = 1; step();
        outs("hold_reopen", 2, 1, 1);
        pas = 0; step();
        chk("hold_reentry_state", int'(st), 3);
        measure(3'd3, 300, n);
        chk("hold_len", n, 101);
        outs("hold_expire", 0, 0, 1);

        // both doors together: driver delay wins
        drv = 1; pas = 1; step();
        chk("both_trig_state", int'(st), 1);
        measure(3'd1, 300, n);
        chk("both_trig_len", n, 81);
        outs("both_sounding", 2, 1, 1);

        // asynchronous reset in the middle of SOUNDING
        step();
        #2;
        rst_n = 1'b0;
        #1;
        outs("async_reset", 0, 0, 1);
        chk("async_reset_fuel", int'(fuel), 0);
        drv = 0; pas = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // ignition during TRIGGERED disarms without sounding
        drv = 1; step();
        chk("drv_trig_state", int'(st), 1);
        drv = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("drv_trig_hold%0d_siren", i), int'(siren), 0);
        end
        ign = 1; step();
        outs("ign_override", 4, 0, 0);
        ign = 0; step();
        chk("ign_release_state", int'(st), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
